vram_arbiter: RTL

- Shares the single-port video RAM between three requesters: the video fetch engine, the CPU port and a DMA/blitter port.
- Grants at most one access per clock and registers the winning command onto the RAM pins.
- Returns read data to the owning requester with a fixed latency.
- Video fetch always wins. CPU beats DMA unless DMA has been starved, which bounds DMA wait time.

---
 rtl/vram_arbiter_if.sv | 52 +++++
 rtl/vram_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its environment.
// The environment holds the three requesters and the RAM. The arbiter sits between them.
interface vram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic              cpu_gnt;
    logic              cpu_rvalid;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_din;
    logic              dma_gnt;
    logic              dma_rvalid;

    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              starve_flag;

    // Arbiter side
    modport slave (
        input  vid_req, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        input  dma_req, dma_we, dma_addr, dma_din,
        input  mem_dout,
        output vid_gnt, vid_rvalid, cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
        output rdata, mem_addr, mem_we, mem_din, starve_flag
    );

    // Requester and RAM side
    modport master (
        output vid_req, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        output dma_req, dma_we, dma_addr, dma_din,
        output mem_dout,
        input  vid_gnt, vid_rvalid, cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
        input  rdata, mem_addr, mem_we, mem_din, starve_flag
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter for video fetch, CPU and DMA.
// Video always wins. CPU beats DMA unless DMA has been denied for STARVE_MAX
// consecutive request cycles. The winning command is registered onto the RAM pins.
// Read data returns two cycles after the grant and is tagged with its owner.
module vram_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           reset,
    vram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        OWN_VID = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DMA = 2'd2
    } owner_e;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic              starve_flag;
    logic              vid_gnt;
    logic              cpu_gnt;
    logic              dma_gnt;
    logic [7:0]        starve_cnt;

    logic              xfer;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_din;
    owner_e            win_owner;

    logic [ADDR_W-1:0] mem_addr_p1;
    logic              mem_we_p1;
    logic [DATA_W-1:0] mem_din_p1;

    logic              tag_vld_p1;
    owner_e            tag_own_p1;
    logic              tag_vld_p2;
    owner_e            tag_own_p2;

    // Fixed-priority grant with the starvation override for DMA
    always_comb begin
        starve_flag = (starve_cnt == STARVE_LIM);
        vid_gnt     = bus.vid_req;
        dma_gnt     = !bus.vid_req && bus.dma_req && (starve_flag || !bus.cpu_req);
        cpu_gnt     = !bus.vid_req && bus.cpu_req && !(starve_flag && bus.dma_req);
    end

    // Select the winning command. With no winner, address and data hold.
    always_comb begin
        xfer      = 1'b0;
        win_we    = 1'b0;
        win_addr  = mem_addr_p1;
        win_din   = mem_din_p1;
        win_owner = OWN_VID;
        if (vid_gnt) begin
            xfer      = 1'b1;
            win_addr  = bus.vid_addr;
        end else if (cpu_gnt) begin
            xfer      = 1'b1;
            win_we    = bus.cpu_we;
            win_addr  = bus.cpu_addr;
            win_din   = bus.cpu_din;
            win_owner = OWN_CPU;
        end else if (dma_gnt) begin
            xfer      = 1'b1;
            win_we    = bus.dma_we;
            win_addr  = bus.dma_addr;
            win_din   = bus.dma_din;
            win_owner = OWN_DMA;
        end
    end

    // Count consecutive denied DMA request cycles, saturating at the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!bus.dma_req || dma_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Stage 1: register the winning command onto the RAM pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_p1 <= '0;
            mem_we_p1   <= 1'b0;
            mem_din_p1  <= '0;
        end else begin
            mem_addr_p1 <= win_addr;
            mem_we_p1   <= xfer && win_we;
            mem_din_p1  <= win_din;
        end
    end

    // Stages 1-2: read tags follow the RAM's one-cycle registered read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld_p1 <= 1'b0;
            tag_own_p1 <= OWN_VID;
            tag_vld_p2 <= 1'b0;
            tag_own_p2 <= OWN_VID;
        end else begin
            tag_vld_p1 <= xfer && !win_we;
            tag_own_p1 <= win_owner;
            tag_vld_p2 <= tag_vld_p1;
            tag_own_p2 <= tag_own_p1;
        end
    end

    assign bus.vid_gnt     = vid_gnt;
    assign bus.cpu_gnt     = cpu_gnt;
    assign bus.dma_gnt     = dma_gnt;
    assign bus.starve_flag = starve_flag;
    assign bus.mem_addr    = mem_addr_p1;
    assign bus.mem_we      = mem_we_p1;
    assign bus.mem_din     = mem_din_p1;
    assign bus.rdata       = bus.mem_dout;
    assign bus.vid_rvalid  = tag_vld_p2 && (tag_own_p2 == OWN_VID);
    assign bus.cpu_rvalid  = tag_vld_p2 && (tag_own_p2 == OWN_CPU);
    assign bus.dma_rvalid  = tag_vld_p2 && (tag_own_p2 == OWN_DMA);
endmodule
